// File: rtl/gpc_pkg.sv
// Shared GPC(2,3;3) definitions: the per-beat weighted count type and accumulator sizing helper.
package gpc_pkg;
  typedef logic [2:0] gpc_cnt_t;

  localparam int GPC23_MAX = 7;

  // Smallest accumulator width that holds a full frame of maximal counts without loss.
  function automatic int gpc_acc_w(input int frame_len);
    return $clog2(GPC23_MAX * frame_len + 1);
  endfunction
endpackage

// File: rtl/gpc_acc_add.sv
// Accumulator adder: acc + zero-extended GPC count. Saturates and flags ovf when GPC_ACC_SAT_EN
// is defined, otherwise wraps modulo 2**ACC_W with ovf held at 0.
module gpc_acc_add
  import gpc_pkg::*;
#(
  parameter int ACC_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  input  gpc_cnt_t         z,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
`ifdef GPC_ACC_SAT_EN
  // Three spare carry bits so narrow accumulators still see the whole count.
  logic [ACC_W+2:0] full;

  always_comb begin
    full = {3'b000, acc} + (ACC_W+3)'(z);
    ovf  = |full[ACC_W+2:ACC_W];
    sum  = ovf ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  end
`else
  always_comb begin
    sum = acc + ACC_W'(z);
    ovf = 1'b0;
  end
`endif
endmodule

// File: rtl/gpc_frame_accum.sv
// Frame accumulator: sums FRAME_LEN GPC(2,3;3) counts per frame with valid/ready on both sides.
// Optional saturation and per-frame overflow flag under macro GPC_ACC_SAT_EN.
module gpc_frame_accum
  import gpc_pkg::*;
#(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] beat_cnt;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             is_last;
  logic             accept;

  gpc_acc_add #(.ACC_W(ACC_W)) u_add (
    .acc (acc),
    .z   (gpc_cnt_t'(in_z)),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Only the closing beat of a frame has to wait for a held result to drain.
  assign is_last  = (beat_cnt == LAST);
  assign in_ready = ~(is_last & out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else begin
      if (accept && is_last) begin
        out_sum   <= add_sum;
        out_valid <= 1'b1;
        acc       <= '0;
        beat_cnt  <= '0;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (accept) begin
          acc      <= add_sum;
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

`ifdef GPC_ACC_SAT_EN
  logic frame_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_ovf <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (is_last) begin
        out_ovf   <= frame_ovf | add_ovf;
        frame_ovf <= 1'b0;
      end else begin
        frame_ovf <= frame_ovf | add_ovf;
      end
    end
  end
`else
  // Adder reports constant 0 when wrapping, so no overflow state is kept.
  assign out_ovf = add_ovf;
`endif
endmodule

// File: tb/tb_gpc_frame_accum.sv
// Randomized and directed check of gpc_frame_accum (three configurations in parallel) against a frame-level model.
module tb_gpc_frame_accum;
  localparam int ND = 3;
  localparam int FLS [ND] = '{16, 4, 4};
  localparam int WS  [ND] = '{8, 8, 4};

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [2:0] in_z;

  logic       rdy [ND];
  logic       ov  [ND];
  logic       of  [ND];
  logic [7:0] s16, s4, s4s_w;
  logic [3:0] s4s;

  int vectors = 0;
  int errs    = 0;

  // Model: true integer running sum and beat count per frame, plus held result.
  int m_sum [ND];
  int m_n   [ND];
  int m_hv  [ND];
  int m_hs  [ND];
  int m_ho  [ND];

  always #5 clk = ~clk;

  gpc_frame_accum #(.FRAME_LEN(16), .ACC_W(8)) d16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_z(in_z),
    .out_valid(ov[0]), .out_ready(out_ready), .out_sum(s16), .out_ovf(of[0]));
  gpc_frame_accum #(.FRAME_LEN(4), .ACC_W(8)) d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_z(in_z),
    .out_valid(ov[1]), .out_ready(out_ready), .out_sum(s4), .out_ovf(of[1]));
  gpc_frame_accum #(.FRAME_LEN(4), .ACC_W(4)) d4s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_z(in_z),
    .out_valid(ov[2]), .out_ready(out_ready), .out_sum(s4s), .out_ovf(of[2]));

  assign s4s_w = {4'b0000, s4s};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] dsum(input int k);
    case (k)
      0:       return {24'd0, s16};
      1:       return {24'd0, s4};
      default: return {24'd0, s4s_w};
    endcase
  endfunction

  function automatic int exp_rdy(input int k);
    return (m_n[k] == FLS[k] - 1 && m_hv[k] != 0 && !out_ready) ? 0 : 1;
  endfunction

  task automatic cmp_all();
    #1;
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("d%0d.in_ready", k), 32'(rdy[k]), 32'(exp_rdy(k)));
      chk($sformatf("d%0d.out_valid", k), 32'(ov[k]), 32'(m_hv[k]));
      chk($sformatf("d%0d.out_sum", k), dsum(k), 32'(m_hs[k]));
      chk($sformatf("d%0d.out_ovf", k), 32'(of[k]), 32'(m_ho[k]));
    end
  endtask

  // Advance one clock; model sees the same inputs the DUTs sample.
  task automatic tick();
    int mx, r;
    @(posedge clk);
    for (int k = 0; k < ND; k++) begin
      mx = (1 << WS[k]) - 1;
      if (rst) begin
        m_sum[k] = 0; m_n[k] = 0; m_hv[k] = 0; m_hs[k] = 0; m_ho[k] = 0;
      end else begin
        r = exp_rdy(k);
        if (in_valid && r != 0) begin
          m_sum[k] += int'(in_z);
          m_n[k]++;
        end
        if (in_valid && r != 0 && m_n[k] == FLS[k]) begin
`ifdef GPC_ACC_SAT_EN
          m_hs[k] = (m_sum[k] > mx) ? mx : m_sum[k];
          m_ho[k] = (m_sum[k] > mx) ? 1 : 0;
`else
          m_hs[k] = m_sum[k] % (mx + 1);
          m_ho[k] = 0;
`endif
          m_hv[k] = 1; m_sum[k] = 0; m_n[k] = 0;
        end else if (out_ready) begin
          m_hv[k] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic v, input logic [2:0] z, input logic ordy);
    in_valid = v; in_z = z; out_ready = ordy;
    cmp_all();
    tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) beat(1'b1, 3'd7, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] seq [8];
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int k = 0; k < ND; k++) begin
      m_sum[k] = 0; m_n[k] = 0; m_hv[k] = 0; m_hs[k] = 0; m_ho[k] = 0;
    end
    rst = 1'b1; in_valid = 1'b1; in_z = 3'd7; out_ready = 1'b1;
    @(negedge clk);
    do_reset(3);
    in_valid = 1'b0;
    cmp_all();
    chk("reset.in_ready", 32'(rdy[0]), 32'd1);
    chk("reset.out_valid", 32'(ov[0]), 32'd0);
    tick();

    // Two 16-beat frames of 7s, no bubbles.
    for (int i = 0; i <= 32; i++) begin
      in_valid = (i < 32); in_z = 3'd7; out_ready = 1'b1;
      cmp_all();
      if (i == 16 || i == 32) begin
        chk("f16.valid", 32'(ov[0]), 32'd1);
        chk("f16.sum", {24'd0, s16}, 32'd112);
      end else if (i > 0) begin
        chk("f16.idle", 32'(ov[0]), 32'd0);
      end
      tick();
    end

    // Back-to-back 4-beat frames 1,2,3,4 then zeros.
    do_reset(1);
    for (int i = 0; i <= 8; i++) begin
      in_valid = (i < 8); in_z = (i < 8) ? seq[i] : 3'd0; out_ready = 1'b1;
      cmp_all();
      if (i == 4) chk("f4.sum10", {24'd0, s4}, 32'd10);
      if (i == 8) chk("f4.sum0", {24'd0, s4}, 32'd0);
      if (i == 4 || i == 8) chk("f4.valid", 32'(ov[1]), 32'd1);
      tick();
    end

    // Backpressure: frame 2's last beat stalls until out_ready rises.
    do_reset(1);
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd2, 1'b1);
    for (int i = 0; i < 3; i++) beat(1'b1, 3'd3, 1'b0);
    in_valid = 1'b1; in_z = 3'd3; out_ready = 1'b0;
    cmp_all();
    chk("bp.stall", 32'(rdy[1]), 32'd0);
    chk("bp.held", {24'd0, s4}, 32'd8);
    tick();
    out_ready = 1'b1;
    cmp_all();
    chk("bp.release", 32'(rdy[1]), 32'd1);
    tick();
    in_valid = 1'b0;
    cmp_all();
    chk("bp.frame2", {24'd0, s4}, 32'd12);
    tick();

    // Reset mid-frame discards the partial sum.
    beat(1'b1, 3'd5, 1'b1);
    beat(1'b1, 3'd5, 1'b1);
    do_reset(1);
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd1, 1'b1);
    in_valid = 1'b0;
    cmp_all();
    chk("rst.mid", {24'd0, s4}, 32'd4);
    tick();

    // Narrow accumulator: 4 x 7 = 28 exceeds 15.
    for (int i = 0; i < 4; i++) beat(1'b1, 3'd7, 1'b1);
    in_valid = 1'b0;
    cmp_all();
`ifdef GPC_ACC_SAT_EN
    chk("narrow.sum", {24'd0, s4s_w}, 32'd15);
    chk("narrow.ovf", 32'(of[2]), 32'd1);
`else
    chk("narrow.sum", {24'd0, s4s_w}, 32'd12);
    chk("narrow.ovf", 32'(of[2]), 32'd0);
`endif
    tick();

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      beat($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom_range(0, 9) < 6);
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
